// File: rtl/trivia_round_ctrl.sv
// Trivia round sequencer: question stepping, submit latch and judging.
// Optional per-question countdown enabled by defining TRIVIA_TIMEOUT_EN.
module trivia_round_ctrl #(
  parameter int NUM_Q     = 20,
  parameter int WIN_SCORE = 10,
  parameter int TICK_DIV  = 50000000,
  parameter int Q_SECONDS = 10
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       submit,
  input  logic [3:0] ans,
  input  logic [3:0] key_ans,
  input  logic [3:0] score,
  output logic [4:0] q_num,
  output logic       res_valid,
  output logic       res_correct,
  output logic       clr_score,
  output logic [3:0] time_left,
  output logic       timed_out,
  output logic       game_over,
  output logic [2:0] state_out
);

  if (NUM_Q < 1 || NUM_Q > 31 || Q_SECONDS < 1 || Q_SECONDS > 15 ||
      TICK_DIV < 1 || WIN_SCORE < 0 || WIN_SCORE > 15) begin : g_bad_params
    $error("trivia_round_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW     = 3'd1,
    WAIT_ANS = 3'd2,
    JUDGE    = 3'd3,
    NEXT     = 3'd4,
    OVER     = 3'd5
  } state_t;

  localparam logic [4:0] NQ   = 5'(NUM_Q);
  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);
  localparam logic [3:0] QS4  = 4'(Q_SECONDS);

  state_t     state, state_n;
  logic       start_d, submit_d;
  logic       start_re, submit_re;
  logic [4:0] q_num_n;
  logic [3:0] ans_q, ans_q_n;
  logic       clr_n;
  logic       ans_hot;

`ifdef TRIVIA_TIMEOUT_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LOAD = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler, ps_n;
  logic [3:0]    tl_n;
  logic          to_n;
`endif

  // Registered edge detection: level delayed once, edge captured once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      start_d   <= 1'b0;
      submit_d  <= 1'b0;
      start_re  <= 1'b0;
      submit_re <= 1'b0;
    end else begin
      start_d   <= start;
      submit_d  <= submit;
      start_re  <= start & ~start_d;
      submit_re <= submit & ~submit_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      q_num     <= 5'd0;
      ans_q     <= 4'd0;
      clr_score <= 1'b0;
`ifdef TRIVIA_TIMEOUT_EN
      time_left <= QS4;
      timed_out <= 1'b0;
      prescaler <= PS_LOAD;
`endif
    end else begin
      state     <= state_n;
      q_num     <= q_num_n;
      ans_q     <= ans_q_n;
      clr_score <= clr_n;
`ifdef TRIVIA_TIMEOUT_EN
      time_left <= tl_n;
      timed_out <= to_n;
      prescaler <= ps_n;
`endif
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    state_n = state;
    q_num_n = q_num;
    ans_q_n = ans_q;
    clr_n   = 1'b0;
`ifdef TRIVIA_TIMEOUT_EN
    tl_n    = time_left;
    to_n    = timed_out;
    ps_n    = prescaler;
`endif
    case (state)
      IDLE, OVER: begin
        if (state == IDLE) q_num_n = 5'd0;
        if (start_re) begin
          clr_n   = 1'b1;
          q_num_n = 5'd1;
          state_n = SHOW;
        end
      end
      SHOW: begin
`ifdef TRIVIA_TIMEOUT_EN
        tl_n = QS4;
        ps_n = PS_LOAD;
        to_n = 1'b0;
`endif
        state_n = WAIT_ANS;
      end
      WAIT_ANS: begin
        if (submit_re) begin
          ans_q_n = ans;
          state_n = JUDGE;
        end
`ifdef TRIVIA_TIMEOUT_EN
        else if (prescaler == '0) begin
          ps_n = PS_LOAD;
          if (time_left <= 4'd1) begin
            tl_n    = 4'd0;
            to_n    = 1'b1;
            ans_q_n = 4'd0;
            state_n = JUDGE;
          end else begin
            tl_n = time_left - 4'd1;
          end
        end else begin
          ps_n = prescaler - PW'(1);
        end
`endif
      end
      JUDGE: state_n = NEXT;
      NEXT: begin
        if (score >= WIN4 || q_num == NQ) begin
          state_n = OVER;
        end else begin
          q_num_n = q_num + 5'd1;
          state_n = SHOW;
        end
      end
      default: begin
        q_num_n = 5'd0;
        state_n = IDLE;
      end
    endcase
  end

`ifndef TRIVIA_TIMEOUT_EN
  assign time_left = QS4;
  assign timed_out = 1'b0;
`endif

  assign ans_hot     = (ans_q != 4'd0) && ((ans_q & (ans_q - 4'd1)) == 4'd0);
  assign res_valid   = (state == JUDGE);
  assign res_correct = res_valid && ans_hot && (ans_q == key_ans);
  assign game_over   = (state == OVER);
  assign state_out   = state;

endmodule
